// File: rtl/input_pre_data_module.sv
// -----------------------------------------------------------------------------
// input_pre_data_module
//
// Front-end row assembler for the PE array. Incoming bytes are collected into
// a write bank, framed by optional left/right pad slots, and a finished row is
// transferred into the parallel_data output register. The output register
// acts as the read bank: it holds the previous row while the write bank fills.
// PEclk is a one-cycle strobe marking each new parallel_data value.
//
// Ports:
//   dout_clk           in   1        clock, rising edge
//   rst_n              in   1        asynchronous active-low reset
//   en                 in   1        global enable; 0 freezes all state
//   i_data_din         in   DATA_W   input byte
//   i_data_din_vld     in   1        input byte valid
//   input_padding      in   8        [7] left pad, [0] right pad, rest ignored
//   i_switch_pingpong  in   1        flush a partial row to the output
//   PEclk              out  1        one-cycle "new row" strobe
//   parallel_data      out  [0:DATA_W*ROW_SLOTS-1]
//                                    slot k = parallel_data[DATA_W*k +: DATA_W]
//
// Build option:
//   PAD_REPLICATE_EN   when defined, pad slots repeat the nearest edge data
//                      byte instead of carrying 0x00.
// -----------------------------------------------------------------------------
module input_pre_data_module #(
  parameter int DATA_W    = 8,
  parameter int ROW_SLOTS = 34
) (
  input  logic                            dout_clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [DATA_W-1:0]               i_data_din,
  input  logic                            i_data_din_vld,
  input  logic [7:0]                      input_padding,
  input  logic                            i_switch_pingpong,
  output logic                            PEclk,
  output logic [0:DATA_W*ROW_SLOTS-1]     parallel_data
);

  localparam int PTR_W = $clog2(ROW_SLOTS + 1);

  logic [DATA_W-1:0]           bank [ROW_SLOTS];
  logic [DATA_W-1:0]           merged [ROW_SLOTS];
  logic [PTR_W-1:0]            ptr;
  logic                        lat_l;
  logic                        lat_r;
  logic                        wr;
  logic                        row_l;
  logic                        row_r;
  logic [PTR_W-1:0]            row_len;
  logic [PTR_W-1:0]            wr_slot;
  logic                        done;
  logic                        flush;
  logic                        load;
  logic [DATA_W-1:0]           left_pad;
  logic [DATA_W-1:0]           right_pad;
  logic [0:DATA_W*ROW_SLOTS-1] next_data;
  logic                        unused_pad_bits;

  assign unused_pad_bits = ^input_padding[6:1];

  // The pad selection of a row is taken from the live input on its first byte
  // and from the latched copy for every later byte, so mid-row changes only
  // affect the following row.
  assign wr      = en & i_data_din_vld;
  assign row_l   = (ptr == '0) ? input_padding[7] : lat_l;
  assign row_r   = (ptr == '0) ? input_padding[0] : lat_r;
  assign row_len = PTR_W'(ROW_SLOTS) - PTR_W'(row_l) - PTR_W'(row_r);
  assign wr_slot = ptr + PTR_W'(row_l);

  // A flush with a coincident byte counts as a single load: the byte is merged
  // into the row that gets flushed. A flush with nothing written is dropped.
  assign done  = wr && (ptr == row_len - PTR_W'(1));
  assign flush = en & i_switch_pingpong & ((ptr != '0) | wr);
  assign load  = done | flush;

`ifdef PAD_REPLICATE_EN
  logic [PTR_W-1:0] last_slot;
  assign last_slot = wr_slot - PTR_W'(1);
`endif

  // Build the row that would be presented if this edge loads the output:
  // the stored bank with the incoming byte already merged in, then pads.
  // Unwritten slots of the bank are zero because the bank is cleared on load.
  always_comb begin
    for (int k = 0; k < ROW_SLOTS; k++) begin
      merged[k] = bank[k];
      if (wr && (wr_slot == PTR_W'(k))) begin
        merged[k] = i_data_din;
      end
    end
    left_pad  = '0;
    right_pad = '0;
`ifdef PAD_REPLICATE_EN
    left_pad = merged[1];
    if (wr) begin
      right_pad = i_data_din;
    end else if (ptr != '0) begin
      right_pad = bank[last_slot];
    end
`endif
    next_data = '0;
    for (int k = 0; k < ROW_SLOTS; k++) begin
      next_data[DATA_W*k +: DATA_W] = merged[k];
    end
    if (row_l) begin
      next_data[0 +: DATA_W] = left_pad;
    end
    if (row_r) begin
      next_data[DATA_W*(ROW_SLOTS-1) +: DATA_W] = right_pad;
    end
  end

  // Write bank, pointer, pad latch and output register. On a load the row is
  // copied out and the bank is emptied on the same edge, so a byte arriving
  // on the very next edge already lands in the new row.
  always_ff @(posedge dout_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ROW_SLOTS; k++) begin
        bank[k] <= '0;
      end
      ptr           <= '0;
      lat_l         <= 1'b0;
      lat_r         <= 1'b0;
      PEclk         <= 1'b0;
      parallel_data <= '0;
    end else begin
      PEclk <= 1'b0;
      if (en) begin
        if (load) begin
          parallel_data <= next_data;
          PEclk         <= 1'b1;
          ptr           <= '0;
          for (int k = 0; k < ROW_SLOTS; k++) begin
            bank[k] <= '0;
          end
        end else if (wr) begin
          bank[wr_slot] <= i_data_din;
          ptr           <= ptr + PTR_W'(1);
        end
        if (wr && (ptr == '0)) begin
          lat_l <= input_padding[7];
          lat_r <= input_padding[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_input_pre_data_module.sv
// -----------------------------------------------------------------------------
// tb_input_pre_data_module
//
// Directed bench for the row assembler: padded and unpadded rows, mid-row pad
// changes, partial-row flushes, back-to-back rows with an enable stall, and an
// asynchronous reset in the middle of a row. Expected rows are built from the
// bytes the bench itself drove.
// -----------------------------------------------------------------------------
module tb_input_pre_data_module;

`ifdef PAD_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic         dout_clk;
  logic         rst_n;
  logic         en;
  logic [7:0]   i_data_din;
  logic         i_data_din_vld;
  logic [7:0]   input_padding;
  logic         i_switch_pingpong;
  logic         PEclk;
  logic [0:271] parallel_data;

  logic [0:271] exp_row;
  int           vectors;
  int           miscompares;

  input_pre_data_module dut (
    .dout_clk          (dout_clk),
    .rst_n             (rst_n),
    .en                (en),
    .i_data_din        (i_data_din),
    .i_data_din_vld    (i_data_din_vld),
    .input_padding     (input_padding),
    .i_switch_pingpong (i_switch_pingpong),
    .PEclk             (PEclk),
    .parallel_data     (parallel_data)
  );

  initial dout_clk = 1'b0;
  always #5 dout_clk = ~dout_clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge dout_clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic check_row(input string tag);
    vectors++;
    assert (parallel_data === exp_row) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, parallel_data, exp_row);
    end
  endtask

  // Expected row for consecutive bytes first, first+1, ... placed after the
  // optional left pad; pads are zero or replicate the edge bytes.
  task automatic build_row(input logic l, input logic r, input logic [7:0] first, input int count);
    logic [7:0] b;
    exp_row = '0;
    b = first;
    for (int i = 0; i < count; i++) begin
      exp_row[8*(i + int'(l)) +: 8] = b;
      b = b + 8'd1;
    end
    if (l && REPL && count > 0) exp_row[0 +: 8] = first;
    if (r && REPL && count > 0) exp_row[8*33 +: 8] = first + 8'(count - 1);
  endtask

  // Drive count consecutive bytes; the strobe must appear only after the last
  // one when that byte completes the row.
  task automatic send_bytes(input string tag, input logic [7:0] first, input int count, input bit completes);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < count; i++) begin
      i_data_din     = b;
      i_data_din_vld = 1'b1;
      tick();
      check_bit(tag, PEclk, completes && (i == count - 1));
      b = b + 8'd1;
    end
    i_data_din_vld = 1'b0;
  endtask

  initial begin
    vectors           = 0;
    miscompares       = 0;
    rst_n             = 1'b0;
    en                = 1'b1;
    i_data_din        = 8'h00;
    i_data_din_vld    = 1'b0;
    input_padding     = 8'h81;
    i_switch_pingpong = 1'b0;

    // Reset state
    repeat (100) tick();
    exp_row = '0;
    check_bit("reset_peclk", PEclk, 1'b0);
    check_row("reset_row");
    rst_n = 1'b1;

    // Both pads, 32 data bytes 0x01..0x20
    send_bytes("lr_strobe", 8'h01, 32, 1'b1);
    build_row(1'b1, 1'b1, 8'h01, 32);
    check_row("lr_row");
    tick();
    check_bit("lr_one_cycle", PEclk, 1'b0);
    check_row("lr_hold");

    // No pads, 34 bytes 0x10..0x31
    input_padding = 8'h00;
    send_bytes("np_strobe", 8'h10, 34, 1'b1);
    build_row(1'b0, 1'b0, 8'h10, 34);
    check_row("np_row");

    // Right pad only; pad change after 5 bytes must not affect this row
    input_padding = 8'h01;
    send_bytes("r_head", 8'h40, 5, 1'b0);
    input_padding = 8'h80;
    send_bytes("r_tail", 8'h45, 28, 1'b1);
    build_row(1'b0, 1'b1, 8'h40, 33);
    check_row("r_row");

    // Left pad only (latched from the changed setting), 33 bytes
    send_bytes("l_strobe", 8'h70, 33, 1'b1);
    build_row(1'b1, 1'b0, 8'h70, 33);
    check_row("l_row");

    // Partial row flush after 5 bytes
    input_padding = 8'h81;
    send_bytes("fl_bytes", 8'hA1, 5, 1'b0);
    i_switch_pingpong = 1'b1;
    tick();
    check_bit("fl_strobe", PEclk, 1'b1);
    build_row(1'b1, 1'b1, 8'hA1, 5);
    check_row("fl_row");
    i_switch_pingpong = 1'b0;
    tick();
    check_bit("fl_one_cycle", PEclk, 1'b0);

    // Flush on an empty row is ignored
    i_switch_pingpong = 1'b1;
    tick();
    check_bit("empty_flush_strobe", PEclk, 1'b0);
    check_row("empty_flush_hold");
    i_switch_pingpong = 1'b0;

    // Flush coincident with the third byte: byte included, single strobe
    send_bytes("co_bytes", 8'hB1, 2, 1'b0);
    i_data_din        = 8'hB3;
    i_data_din_vld    = 1'b1;
    i_switch_pingpong = 1'b1;
    tick();
    check_bit("co_strobe", PEclk, 1'b1);
    build_row(1'b1, 1'b1, 8'hB1, 3);
    check_row("co_row");
    i_data_din_vld    = 1'b0;
    i_switch_pingpong = 1'b0;
    tick();
    check_bit("co_one_cycle", PEclk, 1'b0);

    // Three back-to-back rows, en low for cycles 40..43 inside the second row
    begin
      logic [7:0] b;
      b = 8'h01;
      for (int c = 0; c < 100; c++) begin
        en             = !(c >= 40 && c < 44);
        i_data_din     = b;
        i_data_din_vld = 1'b1;
        tick();
        check_bit("bb_strobe", PEclk, (c == 31) || (c == 67) || (c == 99));
        if (c == 67) begin
          build_row(1'b1, 1'b1, 8'h21, 32);
          check_row("bb_row2");
        end
        if (c == 99) begin
          build_row(1'b1, 1'b1, 8'h41, 32);
          check_row("bb_row3");
        end
        if (en) b = b + 8'd1;
      end
      en             = 1'b1;
      i_data_din_vld = 1'b0;
    end

    // Asynchronous reset after 10 bytes of a row
    send_bytes("rst_bytes", 8'hD1, 10, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_row = '0;
    check_bit("rst_async_peclk", PEclk, 1'b0);
    check_row("rst_async_row");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    send_bytes("post_rst_strobe", 8'h21, 32, 1'b1);
    build_row(1'b1, 1'b1, 8'h21, 32);
    check_row("post_rst_row");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
